// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared entry type and widths for the reorder buffer
// Register-file sizes come from NUM_D_REG / NUM_S_REG when defined elsewhere.
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 16
`endif
package reorder_buffer_pkg;
    localparam int ROB_DEPTH_DEFAULT = 8;
    localparam int RW = $clog2(`NUM_D_REG);
    localparam int SW = $clog2(`NUM_S_REG);
    typedef struct packed {
        logic          valid;
        logic          done;
        logic          mispredict;
        logic          use_rw;
        logic [RW-1:0] old_rw;
        logic          use_rs;
        logic [SW-1:0] old_rs;
    } rob_entry_t;
endpackage

// File: rtl/rob_pointer_ctrl.sv
// rob_pointer_ctrl: head/tail/occupancy tracking for the reorder buffer
module rob_pointer_ctrl #(
    parameter int DEPTH = 8,
    localparam int TW = $clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          n_rst,
    input  logic          alloc,
    input  logic          commit,
    input  logic          flush,
    output logic [TW-1:0] head,
    output logic [TW-1:0] tail,
    output logic [TW:0]   count,
    output logic          full
);
    assign full = count == (TW+1)'(DEPTH);
    // A flush always coincides with the mispredicting commit, so head steps past it
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= head + 1'b1;
            tail  <= head + 1'b1;
            count <= '0;
        end else begin
            head  <= head + TW'(commit);
            tail  <= tail + TW'(alloc);
            count <= count + (TW+1)'(alloc) - (TW+1)'(commit);
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement of out-of-order completions with register return
// Define ROB_PERF_EN to add commit_count / flush_count performance counters.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT,
    localparam int TW = $clog2(ROB_DEPTH)
)(
    input  logic          clk,
    input  logic          n_rst,
    input  logic          alloc_valid,
    input  logic          alloc_use_rw,
    input  logic          alloc_use_rs,
    input  logic [RW-1:0] alloc_old_rw,
    input  logic [SW-1:0] alloc_old_rs,
    output logic          alloc_ready,
    output logic [TW-1:0] alloc_tag,
    input  logic          wb_valid,
    input  logic [TW-1:0] wb_tag,
    input  logic          wb_mispredict,
    output logic          commit_valid,
    output logic          return_r,
    output logic [RW-1:0] r_addr,
    output logic          return_s,
    output logic [SW-1:0] s_addr,
    output logic          flush,
    output logic [TW:0]   count
`ifdef ROB_PERF_EN
    ,
    output logic [31:0]   commit_count,
    output logic [31:0]   flush_count
`endif
);
    rob_entry_t    rob [ROB_DEPTH];
    rob_entry_t    hd;
    logic [TW-1:0] head, tail;
    logic          full, alloc;

    assign hd           = rob[head];
    assign alloc_ready  = ~full & ~flush;
    assign alloc        = alloc_valid & alloc_ready;
    assign alloc_tag    = tail;
    // Gated by reset so nothing retires on the edge that discards the buffer
    assign commit_valid = n_rst & hd.valid & hd.done;
    assign flush        = commit_valid & hd.mispredict;
    assign return_r     = commit_valid & hd.use_rw;
    assign return_s     = commit_valid & hd.use_rs;
    assign r_addr       = hd.old_rw;
    assign s_addr       = hd.old_rs;

    rob_pointer_ctrl #(.DEPTH(ROB_DEPTH)) u_ptr (
        .clk    (clk),
        .n_rst  (n_rst),
        .alloc  (alloc),
        .commit (commit_valid),
        .flush  (flush),
        .head   (head),
        .tail   (tail),
        .count  (count),
        .full   (full)
    );

    always_ff @(posedge clk) begin
        if (!n_rst || flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
        end else begin
            if (commit_valid) rob[head].valid <= 1'b0;
            if (wb_valid && rob[wb_tag].valid) begin
                rob[wb_tag].done       <= 1'b1;
                rob[wb_tag].mispredict <= wb_mispredict;
            end
            if (alloc)
                rob[tail] <= '{valid: 1'b1, done: 1'b0, mispredict: 1'b0,
                               use_rw: alloc_use_rw, old_rw: alloc_old_rw,
                               use_rs: alloc_use_rs, old_rs: alloc_old_rs};
        end
    end

`ifdef ROB_PERF_EN
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            commit_count <= '0;
            flush_count  <= '0;
        end else begin
            commit_count <= commit_count + 32'(commit_valid);
            flush_count  <= flush_count + 32'(flush);
        end
    end
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed table and sequence checks for reorder_buffer (ROB_DEPTH=8)
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic          clk, n_rst;
    logic          alloc_valid, alloc_use_rw, alloc_use_rs;
    logic [RW-1:0] alloc_old_rw;
    logic [SW-1:0] alloc_old_rs;
    logic          alloc_ready;
    logic [2:0]    alloc_tag;
    logic          wb_valid, wb_mispredict;
    logic [2:0]    wb_tag;
    logic          commit_valid, return_r, return_s, flush;
    logic [RW-1:0] r_addr;
    logic [SW-1:0] s_addr;
    logic [3:0]    count;
`ifdef ROB_PERF_EN
    logic [31:0]   commit_count, flush_count;
`endif

    int checks = 0;
    int errors = 0;

    reorder_buffer #(.ROB_DEPTH(8)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .alloc_valid   (alloc_valid),
        .alloc_use_rw  (alloc_use_rw),
        .alloc_use_rs  (alloc_use_rs),
        .alloc_old_rw  (alloc_old_rw),
        .alloc_old_rs  (alloc_old_rs),
        .alloc_ready   (alloc_ready),
        .alloc_tag     (alloc_tag),
        .wb_valid      (wb_valid),
        .wb_tag        (wb_tag),
        .wb_mispredict (wb_mispredict),
        .commit_valid  (commit_valid),
        .return_r      (return_r),
        .r_addr        (r_addr),
        .return_s      (return_s),
        .s_addr        (s_addr),
        .flush         (flush),
        .count         (count)
`ifdef ROB_PERF_EN
        ,
        .commit_count  (commit_count),
        .flush_count   (flush_count)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          av, urw, urs;
        logic [RW-1:0] orw;
        logic [SW-1:0] ors;
        logic          wv;
        logic [2:0]    wt;
        logic          wm;
        logic          e_rdy;
        logic [2:0]    e_tag;
        logic          e_cv, e_rr;
        logic [RW-1:0] e_ra;
        logic          e_rs;
        logic [SW-1:0] e_sa;
        logic          e_fl;
        logic [3:0]    e_cnt;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t v(logic av, logic urw, logic urs, logic [RW-1:0] orw, logic [SW-1:0] ors,
                               logic wv, logic [2:0] wt, logic wm, logic e_rdy, logic [2:0] e_tag,
                               logic e_cv, logic e_rr, logic [RW-1:0] e_ra, logic e_rs,
                               logic [SW-1:0] e_sa, logic e_fl, logic [3:0] e_cnt);
        v = '{av, urw, urs, orw, ors, wv, wt, wm, e_rdy, e_tag, e_cv, e_rr, e_ra, e_rs, e_sa, e_fl, e_cnt};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic av, logic urw, logic urs, logic [RW-1:0] orw, logic [SW-1:0] ors,
                         logic wv, logic [2:0] wt, logic wm);
        @(negedge clk);
        alloc_valid   = av;
        alloc_use_rw  = urw;
        alloc_use_rs  = urs;
        alloc_old_rw  = orw;
        alloc_old_rs  = ors;
        wb_valid      = wv;
        wb_tag        = wt;
        wb_mispredict = wm;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 0;
        idle();
        idle();
        chk("rst_count", 32'(count), 0);
        chk("rst_commit", 32'(commit_valid), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_ret", {return_r, return_s}, 0);
        chk("rst_tag", 32'(alloc_tag), 0);
        n_rst = 1;
    endtask

    initial begin
        n_rst = 0;
        idle();
        // outputs sampled before the edge that consumes the driven inputs
        vecs[0]  = v(1, 1, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = v(1, 1, 0, 6, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        vecs[2]  = v(1, 1, 0, 7, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 2);
        vecs[3]  = v(0, 0, 0, 0, 0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 3);
        vecs[4]  = v(0, 0, 0, 0, 0, 1, 1, 0, 1, 3, 1, 1, 5, 0, 0, 0, 3);
        vecs[5]  = v(0, 0, 0, 0, 0, 1, 2, 0, 1, 3, 1, 1, 6, 0, 0, 0, 2);
        vecs[6]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 1, 7, 0, 0, 0, 1);
        vecs[7]  = v(1, 0, 1, 0, 3, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        vecs[8]  = v(0, 0, 0, 0, 0, 1, 3, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1);
        vecs[9]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0, 1, 3, 0, 1);
        vecs[10] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        vecs[11] = v(0, 0, 0, 0, 0, 1, 4, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].av, vecs[i].urw, vecs[i].urs, vecs[i].orw, vecs[i].ors,
                  vecs[i].wv, vecs[i].wt, vecs[i].wm);
            chk($sformatf("v%0d_ready", i), 32'(alloc_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_tag", i), 32'(alloc_tag), 32'(vecs[i].e_tag));
            chk($sformatf("v%0d_commit", i), 32'(commit_valid), 32'(vecs[i].e_cv));
            chk($sformatf("v%0d_ret_r", i), 32'(return_r), 32'(vecs[i].e_rr));
            chk($sformatf("v%0d_ret_s", i), 32'(return_s), 32'(vecs[i].e_rs));
            chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].e_fl));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            if (vecs[i].e_rr) chk($sformatf("v%0d_r_addr", i), 32'(r_addr), 32'(vecs[i].e_ra));
            if (vecs[i].e_rs) chk($sformatf("v%0d_s_addr", i), 32'(s_addr), 32'(vecs[i].e_sa));
        end

        // fill to capacity, ninth ignored, commit reopens slot 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, RW'(10 + i), 0, 0, 0, 0);
            chk("full_tag", 32'(alloc_tag), i);
            chk("full_rdy", 32'(alloc_ready), 1);
        end
        drive(1, 1, 0, 30, 0, 0, 0, 0);
        chk("full_rdy0", 32'(alloc_ready), 0);
        chk("full_cnt", 32'(count), 8);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        chk("full_cnt_9th", 32'(count), 8);
        idle();
        chk("full_commit", 32'(commit_valid), 1);
        chk("full_raddr", 32'(r_addr), 10);
        chk("full_rdy_commit", 32'(alloc_ready), 0);
        drive(1, 1, 0, 20, 0, 0, 0, 0);
        chk("wrap_rdy", 32'(alloc_ready), 1);
        chk("wrap_tag", 32'(alloc_tag), 0);
        chk("wrap_cnt", 32'(count), 7);
        idle();
        chk("wrap_cnt8", 32'(count), 8);

        // out-of-order writeback retires in order
        do_reset();
        drive(1, 1, 0, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 2, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        chk("ooo_cnt", 32'(count), 2);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        chk("ooo_wait", 32'(commit_valid), 0);
        idle();
        chk("ooo_c0", 32'(commit_valid), 1);
        chk("ooo_a0", 32'(r_addr), 1);
        idle();
        chk("ooo_c1", 32'(commit_valid), 1);
        chk("ooo_a1", 32'(r_addr), 2);
        idle();
        chk("ooo_done", 32'(commit_valid), 0);
        chk("ooo_cnt0", 32'(count), 0);

        // mispredict flushes younger entries
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 1, 0, RW'(1 + i), 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 1);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        chk("mp_c0", 32'(commit_valid), 1);
        chk("mp_a0", 32'(r_addr), 1);
        chk("mp_f0", 32'(flush), 0);
        drive(1, 1, 0, 9, 0, 1, 2, 0);
        chk("mp_c1", 32'(commit_valid), 1);
        chk("mp_r1", 32'(return_r), 1);
        chk("mp_a1", 32'(r_addr), 2);
        chk("mp_f1", 32'(flush), 1);
        chk("mp_rdy", 32'(alloc_ready), 0);
        drive(0, 0, 0, 0, 0, 1, 2, 0);
        chk("mp_cnt", 32'(count), 0);
        chk("mp_fl_after", 32'(flush), 0);
        chk("mp_tag", 32'(alloc_tag), 2);
        chk("mp_rdy1", 32'(alloc_ready), 1);
        drive(0, 0, 0, 0, 0, 1, 3, 0);
        chk("mp_no2", 32'(commit_valid), 0);
        idle();
        chk("mp_no3", 32'(commit_valid), 0);
        chk("mp_cnt0", 32'(count), 0);

        // reset with entries in flight
        do_reset();
        for (int i = 0; i < 5; i++) drive(1, 1, 1, RW'(i), SW'(i), 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        chk("mid_cnt", 32'(count), 5);
        n_rst = 0;
        idle();
        chk("mid_commit", 32'(commit_valid), 0);
        chk("mid_ret", {return_r, return_s}, 0);
        chk("mid_flush", 32'(flush), 0);
        n_rst = 1;
        idle();
        chk("mid_cnt0", 32'(count), 0);
        chk("mid_rdy", 32'(alloc_ready), 1);
        chk("mid_tag", 32'(alloc_tag), 0);
        idle();
        chk("mid_nocommit", 32'(commit_valid), 0);
`ifdef ROB_PERF_EN
        chk("perf_commit", commit_count, 0);
        chk("perf_flush", flush_count, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
